mem_log_trig: RTL and testbench

Multi-channel triggered capture logger, the parametrised successor to the fixed I/Q memory logger. It packs NUM_CH channel samples into one BRAM word. Capture uses a circular buffer with a programmable pre-trigger depth, and the trigger is either immediate or external. After capture, a host readout port reads the buffer in time order relative to the capture start, with wrap-around handled in hardware. The block sits between the filter output and the host/VIO readout logic.

---
 rtl/mem_log_trig_if.sv | 33 +++
 rtl/mem_log_trig.sv | 144 ++++++++++++++
 tb/tb_mem_log_trig.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_log_trig_if.sv
// Capture and readout signal bundle for mem_log_trig.
// master drives samples/commands and reads status; slave is the logger itself.
interface mem_log_trig_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int CH_WIDTH   = 8,
   parameter int NUM_CH     = 2
);
   localparam int W = NUM_CH * CH_WIDTH;

   logic                  i_valid;
   logic [W-1:0]          i_data;
   logic                  i_arm;
   logic                  i_mode;
   logic                  i_trig;
   logic [ADDR_WIDTH-1:0] i_pretrig;
   logic                  i_rd_en;
   logic [ADDR_WIDTH-1:0] i_rd_addr;
   logic [1:0]            o_state;
   logic                  o_mem_full;
   logic [ADDR_WIDTH-1:0] o_trig_addr;
   logic [W-1:0]          o_rd_data;
   logic                  o_rd_valid;

   modport master (
      output i_valid, i_data, i_arm, i_mode, i_trig, i_pretrig, i_rd_en, i_rd_addr,
      input  o_state, o_mem_full, o_trig_addr, o_rd_data, o_rd_valid
   );

   modport slave (
      input  i_valid, i_data, i_arm, i_mode, i_trig, i_pretrig, i_rd_en, i_rd_addr,
      output o_state, o_mem_full, o_trig_addr, o_rd_data, o_rd_valid
   );
endinterface

// File: rtl/mem_log_trig.sv
// Multi-channel triggered capture logger: circular BRAM capture with pre-trigger
// depth, immediate/external trigger, and time-ordered host readout after capture.
module mem_log_trig #(
   parameter int ADDR_WIDTH = 15,
   parameter int CH_WIDTH   = 8,
   parameter int NUM_CH     = 2
) (
   input  logic          clk,
   input  logic          i_rst,
   mem_log_trig_if.slave bus
);
   localparam int W     = NUM_CH * CH_WIDTH;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CW    = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

   state_t                state;
   logic                  mode_q;
   logic [ADDR_WIDTH-1:0] pretrig_q;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic [CW-1:0]         pre_cnt;
   logic [CW-1:0]         post_cnt;

   logic                  capturing;
   logic                  we;
   logic                  rd_fire;
   logic                  trig_fire;
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH-1:0] trig_addr_nxt;
   logic [CW-1:0]         pre_nxt;
   logic [CW-1:0]         post_nxt;
   logic [CW-1:0]         post_goal;

   logic [W-1:0] mem [DEPTH];

   always_comb begin
      capturing     = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
      we            = capturing && bus.i_valid && !i_rst;
      rd_fire       = (state == S_DONE) && bus.i_rd_en && !bus.i_arm;
      trig_fire     = (state == S_WAIT) && (!mode_q || bus.i_trig);
      trig_addr_nxt = wr_ptr - pretrig_q;
      pre_nxt       = pre_cnt + CW'(1);
      // The trigger-cycle write is post sample 1, whatever post_cnt holds.
      post_nxt      = (state == S_WAIT) ? CW'(1) : post_cnt + CW'(1);
      post_goal     = CW'(DEPTH) - {1'b0, pretrig_q};
      // One shared port: readout addresses relative to capture start, else write pointer.
      addr          = (state == S_DONE) ? start_addr + bus.i_rd_addr : wr_ptr;
   end

   // Single-port BRAM with a synchronous, resettable output register
   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= bus.i_data;
      if (i_rst)
         bus.o_rd_data <= '0;
      else if (rd_fire)
         bus.o_rd_data <= mem[addr];
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state            <= S_IDLE;
         bus.o_state      <= 2'd0;
         mode_q           <= 1'b0;
         pretrig_q        <= '0;
         wr_ptr           <= '0;
         start_addr       <= '0;
         pre_cnt          <= '0;
         post_cnt         <= '0;
         bus.o_mem_full   <= 1'b0;
         bus.o_trig_addr  <= '0;
         bus.o_rd_valid   <= 1'b0;
      end else begin
         bus.o_rd_valid <= rd_fire;
         if (we)
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);

         case (state)
            S_IDLE, S_DONE: begin
               if (bus.i_arm) begin
                  mode_q         <= bus.i_mode;
                  pretrig_q      <= bus.i_pretrig;
                  wr_ptr         <= '0;
                  pre_cnt        <= '0;
                  post_cnt       <= '0;
                  bus.o_mem_full <= 1'b0;
                  if (bus.i_pretrig != '0) begin
                     state       <= S_PRE;
                     bus.o_state <= 2'd1;
                  end else begin
                     state       <= S_WAIT;
                     bus.o_state <= 2'd2;
                  end
               end
            end

            S_PRE: begin
               if (we) begin
                  pre_cnt <= pre_nxt;
                  if (pre_nxt == {1'b0, pretrig_q}) begin
                     state       <= S_WAIT;
                     bus.o_state <= 2'd2;
                  end
               end
            end

            S_WAIT: begin
               if (trig_fire) begin
                  start_addr      <= trig_addr_nxt;
                  bus.o_trig_addr <= trig_addr_nxt;
                  state           <= S_POST;
                  bus.o_state     <= 2'd3;
                  if (we) begin
                     post_cnt <= post_nxt;
                     if (post_nxt == post_goal) begin
                        state          <= S_DONE;
                        bus.o_state    <= 2'd0;
                        bus.o_mem_full <= 1'b1;
                     end
                  end
               end
            end

            S_POST: begin
               if (we) begin
                  post_cnt <= post_nxt;
                  if (post_nxt == post_goal) begin
                     state          <= S_DONE;
                     bus.o_state    <= 2'd0;
                     bus.o_mem_full <= 1'b1;
                  end
               end
            end

            default: begin
               state       <= S_IDLE;
               bus.o_state <= 2'd0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_log_trig.sv
// Self-checking bench for mem_log_trig: directed table, corner sequences and
// randomized captures against a sample-history reference model.
module tb_mem_log_trig;
   localparam int AW    = 4;
   localparam int CHW   = 8;
   localparam int NCH   = 2;
   localparam int W     = CHW * NCH;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic i_rst;
   always #5 clk = ~clk;

   mem_log_trig_if #(.ADDR_WIDTH(AW), .CH_WIDTH(CHW), .NUM_CH(NCH)) bus();

   mem_log_trig #(.ADDR_WIDTH(AW), .CH_WIDTH(CHW), .NUM_CH(NCH)) dut (
      .clk   (clk),
      .i_rst (i_rst),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: the history of every sample written since arm, plus the
   // history index of the trigger sample. Captured word k = hist[tidx - pre + k].
   int         m_mode, m_pre, m_writes, m_tidx, m_start;
   bit         m_trig, m_done;
   logic [W-1:0] hist[$];

   typedef struct {
      int mode; int pre; int vpat; int trig_n; int trig_n2; int exp_trig;
      int k0; int e0; int k1; int e1; int k2; int e2;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.i_valid   = 1'b0;
      bus.i_arm     = 1'b0;
      bus.i_trig    = 1'b0;
      bus.i_rd_en   = 1'b0;
      bus.i_rd_addr = '0;
   endtask

   function automatic logic [W-1:0] ramp(input int n);
      logic [7:0] b;
      b = n[7:0];
      return {b, b};
   endfunction

   function automatic void model_arm(input int mode, input int pre);
      m_mode = mode; m_pre = pre; m_writes = 0; m_tidx = 0; m_start = 0;
      m_trig = 0; m_done = 0;
      hist.delete();
   endfunction

   function automatic void model_step(input bit v, input logic [W-1:0] d, input bit t);
      if (m_done) return;
      if (!m_trig && m_writes >= m_pre && (m_mode == 0 || t)) begin
         m_trig  = 1;
         m_tidx  = m_writes;
         m_start = (m_writes - m_pre) & (DEPTH - 1);
      end
      if (v) begin
         hist.push_back(d);
         m_writes++;
      end
      if (m_trig && m_writes == m_tidx + DEPTH - m_pre) m_done = 1;
   endfunction

   function automatic int model_state();
      if (m_done) return 0;
      if (!m_trig && m_writes < m_pre) return 1;
      if (!m_trig) return 2;
      return 3;
   endfunction

   function automatic logic [W-1:0] model_word(input int k);
      return hist[m_tidx - m_pre + k];
   endfunction

   // vpat: 0 continuous, 1 alternate, 2 random. trig_n -1 = random trigger.
   task automatic capture(input int mode, input int pre, input int vpat,
                          input int trig_n, input int trig_n2, input bit side);
      int n;
      int cyc;
      bit v;
      bit t;
      logic [W-1:0] d;
      quiet();
      bus.i_arm     = 1'b1;
      bus.i_mode    = mode[0];
      bus.i_pretrig = AW'(pre);
      model_arm(mode, pre);
      tick();
      bus.i_arm = 1'b0;
      chk("arm_state", 32'(bus.o_state), 32'(model_state()));
      chk("arm_full", 32'(bus.o_mem_full), 0);
      n = 0;
      cyc = 0;
      while (!m_done && cyc < 1000) begin
         case (vpat)
            0:       v = 1'b1;
            1:       v = (cyc % 2) == 0;
            default: v = $urandom_range(0, 3) != 0;
         endcase
         d = (vpat == 2) ? W'($urandom) : ramp(n);
         if (trig_n == -1) t = $urandom_range(0, 7) == 0;
         else              t = v && (n == trig_n || n == trig_n2);
         bus.i_valid = v;
         bus.i_data  = d;
         bus.i_trig  = t;
         if (side) begin
            bus.i_arm     = $urandom_range(0, 1) == 1;
            bus.i_rd_en   = $urandom_range(0, 1) == 1;
            bus.i_rd_addr = AW'($urandom);
         end
         model_step(v, d, t);
         if (v) n++;
         tick();
         cyc++;
         chk("cap_state", 32'(bus.o_state), 32'(model_state()));
         chk("cap_full", 32'(bus.o_mem_full), 32'(m_done));
         chk("cap_rd_valid", 32'(bus.o_rd_valid), 0);
      end
      quiet();
      chk("capture_done", 32'(bus.o_mem_full), 1);
      chk("trig_addr_model", 32'(bus.o_trig_addr), 32'(m_start));
   endtask

   task automatic read_one(input int k, input logic [W-1:0] exp, input string name);
      bus.i_rd_en   = 1'b1;
      bus.i_rd_addr = AW'(k);
      tick();
      bus.i_rd_en = 1'b0;
      chk({name, "_valid"}, 32'(bus.o_rd_valid), 1);
      chk(name, 32'(bus.o_rd_data), 32'(exp));
   endtask

   task automatic readback();
      for (int k = 0; k < DEPTH; k++) begin
         bus.i_rd_en   = 1'b1;
         bus.i_rd_addr = AW'(k);
         tick();
         chk("stream_valid", 32'(bus.o_rd_valid), 1);
         chk("stream_data", 32'(bus.o_rd_data), 32'(model_word(k)));
      end
      bus.i_rd_en = 1'b0;
      tick();
      chk("idle_valid", 32'(bus.o_rd_valid), 0);
      chk("hold_data", 32'(bus.o_rd_data), 32'(model_word(DEPTH - 1)));
      for (int r = 0; r < 3; r++) begin
         int k;
         k = $urandom_range(0, DEPTH - 1);
         read_one(k, model_word(k), "rand_read");
      end
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{0, 0, 0, -2, -2, 0,  0, 0,  5, 5,  15, 15};
      vecs[1] = '{1, 4, 0, 22, -2, 2,  0, 18, 4, 22, 15, 33};
      vecs[2] = '{1, 8, 0, 10, 3,  2,  0, 2,  8, 10, 15, 17};
      vecs[3] = '{0, 0, 1, -2, -2, 0,  0, 0,  7, 7,  15, 15};
      vecs[4] = '{1, 15, 0, 20, -2, 5, 0, 5,  14, 19, 15, 20};
      vecs[5] = '{1, 0, 0, 5,  -2, 5,  0, 5,  10, 15, 15, 20};

      quiet();
      bus.i_data    = '0;
      bus.i_mode    = 1'b0;
      bus.i_pretrig = '0;
      i_rst = 1'b1;
      repeat (3) tick();
      i_rst = 1'b0;
      tick();

      chk("rst_full", 32'(bus.o_mem_full), 0);
      chk("rst_rd_valid", 32'(bus.o_rd_valid), 0);
      chk("rst_rd_data", 32'(bus.o_rd_data), 0);
      chk("rst_trig_addr", 32'(bus.o_trig_addr), 0);
      chk("rst_state", 32'(bus.o_state), 0);
      for (int i = 0; i < 3; i++) begin
         bus.i_rd_en = 1'b1;
         bus.i_rd_addr = AW'(i);
         tick();
         chk("idle_rd_valid", 32'(bus.o_rd_valid), 0);
      end
      bus.i_rd_en = 1'b0;

      foreach (vecs[i]) begin
         capture(vecs[i].mode, vecs[i].pre, vecs[i].vpat, vecs[i].trig_n, vecs[i].trig_n2, 1'b0);
         chk("vec_trig_addr", 32'(bus.o_trig_addr), 32'(vecs[i].exp_trig));
         read_one(vecs[i].k0, ramp(vecs[i].e0), "vec_idx_a");
         read_one(vecs[i].k1, ramp(vecs[i].e1), "vec_idx_b");
         read_one(vecs[i].k2, ramp(vecs[i].e2), "vec_idx_c");
         readback();
      end

      // Reset during POST, then reset coinciding with a read in DONE
      quiet();
      bus.i_arm = 1'b1; bus.i_mode = 1'b0; bus.i_pretrig = '0;
      tick();
      bus.i_arm = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.i_valid = 1'b1;
         bus.i_data  = ramp(100 + i);
         tick();
      end
      chk("mid_post_state", 32'(bus.o_state), 3);
      bus.i_valid = 1'b0;
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk("post_rst_state", 32'(bus.o_state), 0);
      chk("post_rst_full", 32'(bus.o_mem_full), 0);
      chk("post_rst_trig", 32'(bus.o_trig_addr), 0);

      capture(0, 0, 0, -2, -2, 1'b0);
      readback();
      bus.i_rd_en = 1'b1;
      bus.i_rd_addr = AW'(3);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      bus.i_rd_en = 1'b0;
      chk("rd_rst_valid", 32'(bus.o_rd_valid), 0);
      chk("rd_rst_data", 32'(bus.o_rd_data), 0);
      chk("rd_rst_full", 32'(bus.o_mem_full), 0);

      capture(0, 0, 0, -2, -2, 1'b0);
      chk("rearm_trig_addr", 32'(bus.o_trig_addr), 0);
      readback();

      for (int it = 0; it < 20; it++)
         begin
            int md;
            int pr;
            md = $urandom_range(0, 1);
            pr = $urandom_range(0, DEPTH - 1);
            capture(md, pr, 2, -1, -2, 1'b1);
            readback();
         end

      // Arm and read together in DONE: arm wins
      bus.i_arm = 1'b1; bus.i_mode = 1'b1; bus.i_pretrig = AW'(2);
      bus.i_rd_en = 1'b1; bus.i_rd_addr = AW'(1);
      tick();
      quiet();
      chk("arm_rd_valid", 32'(bus.o_rd_valid), 0);
      chk("arm_rd_state", 32'(bus.o_state), 1);
      chk("arm_rd_full", 32'(bus.o_mem_full), 0);
      bus.i_rd_en = 1'b1;
      tick();
      bus.i_rd_en = 1'b0;
      chk("pre_rd_valid", 32'(bus.o_rd_valid), 0);

      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk("final_state", 32'(bus.o_state), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
